// File: rtl/aes_dout_streamer.sv
// Output stage after the 128->32 ciphertext FIFO: pops words into a 2-entry
// output/skid buffer and presents them on a valid/ready stream with block framing.
module aes_dout_streamer #(
  parameter int DATA_WH         = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_WH          = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic [DATA_WH-1:0] fifo_data,
  output logic               fifo_read,
  output logic               m_valid,
  output logic [DATA_WH-1:0] m_data,
  output logic               m_last,
  input  logic               m_ready,
  output logic [CNT_WH-1:0]  block_count,
  output logic               busy
);

  localparam int IDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DATA_WH-1:0] out_reg;
  logic [DATA_WH-1:0] skid_reg;
  logic [IDX_W-1:0]   word_idx;
  logic               pop;
  logic               xfer;
  logic               load_out_fifo;
  logic               load_out_skid;
  logic               load_skid;

  // The pop decision looks only at registered state, never at m_ready.
  assign pop         = resetn & enable & ~fifo_empty & (state != TWO);
  assign fifo_read   = pop;
  assign m_valid     = (state != EMPTY);
  assign m_data      = out_reg;
  assign m_last      = m_valid & (word_idx == LAST_IDX);
  assign busy        = m_valid;
  assign xfer        = m_valid & m_ready;

  always_comb begin
    state_nxt     = state;
    load_out_fifo = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (pop) begin
          load_out_fifo = 1'b1;
          state_nxt     = ONE;
        end
      end
      ONE: begin
        if (pop && xfer) begin
          load_out_fifo = 1'b1;
        end else if (pop) begin
          load_skid     = 1'b1;
          state_nxt     = TWO;
        end else if (xfer) begin
          state_nxt     = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          load_out_skid = 1'b1;
          state_nxt     = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Output register stage: state, head word and block framing counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= EMPTY;
      out_reg     <= '0;
      word_idx    <= '0;
      block_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_out_fifo) begin
        out_reg <= fifo_data;
      end else if (load_out_skid) begin
        out_reg <= skid_reg;
      end
      if (xfer) begin
        word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
      end
      if (xfer && m_last) begin
        block_count <= block_count + 1'b1;
      end
    end
  end

  // Skid stage: pure data, only meaningful while state is TWO.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_reg <= fifo_data;
    end
  end

endmodule

// File: tb/tb_aes_dout_streamer.sv
// Directed bench for aes_dout_streamer: FIFO model feeds the DUT, a monitor
// collects transfers, and each test compares them against hand-derived values.
module tb_aes_dout_streamer;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } rx_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_read;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic [15:0] block_count;
  logic        busy;

  logic        fifo_read_s;
  logic        m_valid_s;
  logic [31:0] m_data_s;
  logic        m_last_s;
  logic [1:0]  block_count_s;
  logic        busy_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pops     = 0;
  int diverge  = 0;

  logic [31:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        flush  = 1'b0;

  rx_t  rx_q[$];
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;

  always #5 clk = ~clk;

  aes_dout_streamer dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .block_count(block_count),
    .busy       (busy)
  );

  // Narrow counter copy: same stimulus, lets the wrap be seen in a few blocks.
  aes_dout_streamer #(.CNT_WH(2)) dut_small (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read_s),
    .m_valid    (m_valid_s),
    .m_data     (m_data_s),
    .m_last     (m_last_s),
    .m_ready    (m_ready),
    .block_count(block_count_s),
    .busy       (busy_s)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read) begin
      rd_ptr <= rd_ptr + 8'd1;
      pops   <= pops + 1;
    end
  end

  always @(negedge clk) begin
    rx_t r;
    if (prev_stall) begin
      checks++;
      if (!(m_valid && m_data == prev_data && m_last == prev_last)) begin
        failures++;
        $display("FAIL hold_stable: valid=%0b data=0x%08h last=%0b required valid=1 data=0x%08h last=%0b",
                 m_valid, m_data, m_last, prev_data, prev_last);
      end
    end
    prev_stall = resetn & m_valid & ~m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (fifo_empty || !resetn) begin
      checks++;
      if (fifo_read) begin
        failures++;
        $display("FAIL read_guard: fifo_read=1 required 0 (empty=%0b resetn=%0b)", fifo_empty, resetn);
      end
    end
    if (fifo_read_s != fifo_read || m_valid_s != m_valid || m_data_s != m_data ||
        m_last_s != m_last || busy_s != busy) begin
      diverge++;
    end
    if (resetn && m_valid && m_ready) begin
      r.data = m_data;
      r.last = m_last;
      r.cyc  = cyc;
      rx_q.push_back(r);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h required=0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rx_q.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: got=%0d words required=%0d", name, rx_q.size(), n);
    end
  endtask

  task automatic do_reset();
    step();
    resetn = 1'b0;
    flush  = 1'b1;
    step();
    flush  = 1'b0;
    step();
    resetn = 1'b1;
    rx_q.delete();
  endtask

  initial begin
    vec_t        t2[4];
    logic [31:0] w[64];
    int          p0;
    int          k;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        t2[4];
    logic [31:0] w[64];
    int          p0;
    int          k;

    t2[0] = '{32'h00112233, 1'b0};
    t2[1] = '{32'h44556677, 1'b0};
    t2[2] = '{32'h8899AABB, 1'b0};
    t2[3] = '{32'hCCDDEEFF, 1'b1};

    // T1: reset held with a non-empty FIFO
    resetn  = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b0;
    push(32'hDEAD0001);
    push(32'hDEAD0002);
    repeat (3) step();
    @(negedge clk);
    chk("t1_fifo_read", fifo_read, 0);
    chk("t1_m_valid", m_valid, 0);
    chk("t1_block_count", block_count, 0);
    chk("t1_busy", busy, 0);
    chk("t1_m_data", m_data, 0);
    chk("t1_m_last", m_last, 0);
    do_reset();

    // T2: one block with the sink always ready
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(t2[i].data);
    wait_rx(4, 20, "t2");
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      chk($sformatf("t2_data%0d", i), rx_q[i].data, t2[i].data);
      chk($sformatf("t2_last%0d", i), rx_q[i].last, t2[i].last);
      chk($sformatf("t2_cyc%0d", i), rx_q[i].cyc - rx_q[0].cyc, i);
    end
    settle();
    chk("t2_block_count", block_count, 1);

    // T3: backpressure then release
    do_reset();
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      w[i] = 32'hB0000000 + i * 32'h00010101;
      push(w[i]);
    end
    @(negedge clk);
    chk("t3_pre_valid", m_valid, 0);
    step();
    @(negedge clk);
    chk("t3_latency_valid", m_valid, 1);
    chk("t3_latency_data", m_data, w[0]);
    repeat (4) step();
    @(negedge clk);
    chk("t3_stall_read", fifo_read, 0);
    chk("t3_stall_pops", pops - p0, 2);
    chk("t3_stall_data", m_data, w[0]);
    chk("t3_stall_busy", busy, 1);
    step();
    m_ready = 1'b1;
    wait_rx(8, 30, "t3");
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      chk($sformatf("t3_data%0d", i), rx_q[i].data, w[i]);
      chk($sformatf("t3_last%0d", i), rx_q[i].last, (i % 4 == 3) ? 1 : 0);
      chk($sformatf("t3_cyc%0d", i), rx_q[i].cyc - rx_q[0].cyc, i);
    end
    settle();
    chk("t3_block_count", block_count, 2);
    chk("t3_small_count", block_count_s, 2);

    // T4: 50% random sink over 64 words
    do_reset();
    for (int i = 0; i < 64; i++) begin
      w[i] = 32'hC0DE0000 ^ (i * 32'h01030507);
      push(w[i]);
    end
    k = 0;
    while (rx_q.size() < 64 && k < 2000) begin
      step();
      m_ready = 1'($urandom_range(0, 1));
      k++;
    end
    chk("t4_count", rx_q.size(), 64);
    for (int i = 0; i < 64 && i < rx_q.size(); i++) begin
      chk($sformatf("t4_data%0d", i), rx_q[i].data, w[i]);
      chk($sformatf("t4_last%0d", i), rx_q[i].last, (i % 4 == 3) ? 1 : 0);
    end
    step();
    m_ready = 1'b1;
    settle();
    chk("t4_block_count", block_count, 16);
    chk("t4_small_wrap", block_count_s, 0);

    // T5: FIFO underflow in the middle of a block
    do_reset();
    push(32'h55000001);
    push(32'h55000002);
    wait_rx(2, 20, "t5a");
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk($sformatf("t5_gap_valid%0d", i), m_valid, 0);
    end
    step();
    push(32'h55000003);
    push(32'h55000004);
    wait_rx(4, 20, "t5b");
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      chk($sformatf("t5_data%0d", i), rx_q[i].data, 32'h55000001 + i);
      chk($sformatf("t5_last%0d", i), rx_q[i].last, (i == 3) ? 1 : 0);
    end
    settle();
    chk("t5_block_count", block_count, 1);

    // T6: reset mid-block with a word buffered, then enable gating
    do_reset();
    push(32'h66000001);
    push(32'h66000002);
    wait_rx(2, 20, "t6a");
    step();
    m_ready = 1'b0;
    push(32'h66000003);
    step();
    @(negedge clk);
    chk("t6_buffered", m_valid, 1);
    step();
    resetn = 1'b0;
    flush  = 1'b1;
    step();
    flush  = 1'b0;
    step();
    resetn = 1'b1;
    rx_q.delete();
    @(negedge clk);
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_count", block_count, 0);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h77000000 + i);
    wait_rx(4, 20, "t6b");
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      chk($sformatf("t6_data%0d", i), rx_q[i].data, 32'h77000000 + i);
      chk($sformatf("t6_last%0d", i), rx_q[i].last, (i == 3) ? 1 : 0);
    end
    settle();
    chk("t6_block_count", block_count, 1);

    step();
    rx_q.delete();
    m_ready = 1'b0;
    push(32'h88000001);
    step();
    enable = 1'b0;
    push(32'h88000002);
    push(32'h88000003);
    p0 = pops;
    step();
    @(negedge clk);
    chk("t6_en_read", fifo_read, 0);
    chk("t6_en_valid", m_valid, 1);
    chk("t6_en_data", m_data, 32'h88000001);
    step();
    m_ready = 1'b1;
    wait_rx(1, 10, "t6c");
    step();
    @(negedge clk);
    chk("t6_drain_valid", m_valid, 0);
    chk("t6_drain_read", fifo_read, 0);
    chk("t6_drain_pops", pops - p0, 0);
    step();
    enable = 1'b1;
    wait_rx(3, 20, "t6d");
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      chk($sformatf("t6_en_data%0d", i), rx_q[i].data, 32'h88000001 + i);
      chk($sformatf("t6_en_last%0d", i), rx_q[i].last, 0);
    end
    settle();
    chk("t6_small_count", block_count_s, 1);
    chk("instances_agree", diverge, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
